// File: rtl/data_mem_responder_if.sv
// Purpose: load/store handshake bundle between the CPU datapath (master)
// and the data memory responder (slave).
// Signals:
//   addr   - byte address, sampled when a request is accepted
//   wdata  - store data, sampled when a request is accepted
//   funct3 - access size/sign selector (B, H, W, BU, HU)
//   rreq   - one-cycle load request pulse
//   cwe    - one-cycle store request pulse
//   rdata  - load result, held until the next completion
//   rdy    - 1 when idle/complete, 0 while an access is in flight
//   err    - 1 when the last completed access was misaligned or illegal
interface data_mem_responder_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  funct3;
  logic        rreq;
  logic        cwe;
  logic [31:0] rdata;
  logic        rdy;
  logic        err;

  modport master (
    output addr, wdata, funct3, rreq, cwe,
    input  rdata, rdy, err
  );

  modport slave (
    input  addr, wdata, funct3, rreq, cwe,
    output rdata, rdy, err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Purpose: memory-side responder for the load/store handshake. A one-cycle
// rreq (load) or cwe (store) pulse is accepted while idle; the address, data,
// size and operation are latched, and the access is performed on an internal
// word array LAT cycles later, at which point rdy returns high.
// Ports:
//   clk   - clock, all state updates on the rising edge
//   rst_n - asynchronous active-low reset
//   bus   - slave side of data_mem_responder_if (addr/wdata/funct3/rreq/cwe
//           in, rdata/rdy/err out)
// Parameters:
//   DEPTH - number of 32-bit words in the array (power of two)
//   LAT   - cycles from acceptance to completion, 1..15
module data_mem_responder #(
  parameter int DEPTH = 1024,
  parameter int LAT   = 2
) (
  input logic           clk,
  input logic           rst_n,
  data_mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    funct3_q, funct3_d;
  logic          store_q, store_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] word_idx;
  logic [1:0]    byte_off;
  logic [31:0]   mem_word;
  logic [31:0]   shifted;
  logic [31:0]   load_val;
  logic [31:0]   wdata_rep;
  logic [3:0]    byte_en;
  logic          legal;
  logic          mem_we;

  // Address bits above the array index are intentionally ignored (wrap).
  logic unused_addr;
  assign unused_addr = ^bus.addr[31:AW+2];

  // Access decode from the latched request: legality, load extraction and
  // store byte lanes. Store data is replicated so each lane sees its slice.
  always_comb begin
    byte_off  = addr_q[1:0];
    word_idx  = addr_q[AW+1:2];
    mem_word  = mem[word_idx];
    shifted   = mem_word >> {byte_off, 3'b000};
    legal     = 1'b0;
    load_val  = '0;
    byte_en   = '0;
    wdata_rep = wdata_q;
    case (funct3_q)
      3'b000: begin
        legal     = 1'b1;
        load_val  = {{24{shifted[7]}}, shifted[7:0]};
        byte_en   = 4'b0001 << byte_off;
        wdata_rep = {4{wdata_q[7:0]}};
      end
      3'b001: begin
        legal     = ~byte_off[0];
        load_val  = {{16{shifted[15]}}, shifted[15:0]};
        byte_en   = byte_off[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_q[15:0]}};
      end
      3'b010: begin
        legal    = (byte_off == 2'b00);
        load_val = mem_word;
        byte_en  = 4'b1111;
      end
      3'b100: begin
        legal    = ~store_q;
        load_val = {24'b0, shifted[7:0]};
      end
      3'b101: begin
        legal    = ~store_q & ~byte_off[0];
        load_val = {16'b0, shifted[15:0]};
      end
      default: legal = 1'b0;
    endcase
  end

  // Next-state logic: accept a request only in IDLE (store wins over load),
  // count down in BUSY and perform the access on the edge the count is zero.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    store_d  = store_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    mem_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cwe || bus.rreq) begin
          addr_d   = bus.addr[AW+1:0];
          wdata_d  = bus.wdata;
          funct3_d = bus.funct3;
          store_d  = bus.cwe;
          cnt_d    = 4'(LAT - 1);
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          if (!legal) begin
            rdata_d = '0;
            err_d   = 1'b1;
          end else if (store_q) begin
            mem_we = 1'b1;
            err_d  = 1'b0;
          end else begin
            rdata_d = load_val;
            err_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers; an in-flight access is dropped on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      store_q  <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      store_q  <= store_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Array contents survive reset, so the write port has no reset term.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  assign bus.rdy   = (state_q == IDLE);
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Purpose: scoreboard bench for data_mem_responder. Three instances with
// LAT = 2, 1 and 15 share one clock; each request that should complete pushes
// its expected rdata/err into a queue, and a monitor pops and compares on
// every rdy rising edge, also checking that rdy stayed low exactly LAT cycles.
module tb_data_mem_responder;

  localparam int N_INST = 3;

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_a  [N_INST];
  logic [31:0] addr_a   [N_INST];
  logic [31:0] wdata_a  [N_INST];
  logic [2:0]  funct3_a [N_INST];
  logic        rreq_a   [N_INST];
  logic        cwe_a    [N_INST];
  logic [31:0] rdata_a  [N_INST];
  logic        rdy_a    [N_INST];
  logic        err_a    [N_INST];

  logic        prev_rdy [N_INST];
  int          low_cnt  [N_INST];

  int n_pass  = 0;
  int n_total = 0;

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 15);
  endfunction

  data_mem_responder_if bus_if [N_INST] ();

  for (genvar g = 0; g < N_INST; g++) begin : g_dut
    assign bus_if[g].addr   = addr_a[g];
    assign bus_if[g].wdata  = wdata_a[g];
    assign bus_if[g].funct3 = funct3_a[g];
    assign bus_if[g].rreq   = rreq_a[g];
    assign bus_if[g].cwe    = cwe_a[g];
    assign rdata_a[g]       = bus_if[g].rdata;
    assign rdy_a[g]         = bus_if[g].rdy;
    assign err_a[g]         = bus_if[g].err;

    data_mem_responder #(
      .DEPTH(1024),
      .LAT  ((g == 0) ? 2 : ((g == 1) ? 1 : 15))
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n_a[g]),
      .bus  (bus_if[g])
    );
  end

  // Single comparison point: every check steps n_total and, on a match, n_pass.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Monitor: a completion is rdy going 0 -> 1 while out of reset.
  initial begin
    for (int i = 0; i < N_INST; i++) begin
      prev_rdy[i] = 1'b1;
      low_cnt[i]  = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < N_INST; i++) begin
      if (!rst_n_a[i]) begin
        prev_rdy[i] = 1'b1;
        low_cnt[i]  = 0;
      end else begin
        if (!rdy_a[i]) begin
          low_cnt[i]++;
        end else if (!prev_rdy[i]) begin
          if (sb_q.size() == 0 || sb_q[0].inst != i) begin
            checkOutput($sformatf("unexpected_completion_inst%0d", i), 32'd1, 32'd0);
          end else begin
            mon_e = sb_q.pop_front();
            checkOutput($sformatf("rdata_inst%0d", i), rdata_a[i], mon_e.rdata);
            checkOutput($sformatf("err_inst%0d", i), {31'b0, err_a[i]}, {31'b0, mon_e.err});
            checkOutput($sformatf("rdy_low_cycles_inst%0d", i), low_cnt[i], lat_of(i));
          end
          low_cnt[i] = 0;
        end
        prev_rdy[i] = rdy_a[i];
      end
    end
  end

  // Wait (bounded) until every expected completion has been seen and the
  // instance is idle again.
  task automatic waitDone(input int inst);
    bool_loop: for (int k = 0; k < 200; k++) begin
      if (sb_q.size() == 0 && rdy_a[inst] === 1'b1) return;
      @(negedge clk);
      #1;
    end
    checkOutput($sformatf("timeout_inst%0d_pending", inst), sb_q.size(), 32'd0);
    sb_q.delete();
  endtask

  // Drive a one-cycle request pulse; optionally record its expected result.
  task automatic applyStimulus(input int inst, input logic rq, input logic we,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [2:0] f3, input logic expect_resp,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input logic wait_idle);
    exp_t e;
    if (wait_idle) waitDone(inst);
    @(negedge clk);
    #1;
    addr_a[inst]   = a;
    wdata_a[inst]  = wd;
    funct3_a[inst] = f3;
    rreq_a[inst]   = rq;
    cwe_a[inst]    = we;
    if (expect_resp) begin
      e.inst  = inst;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      sb_q.push_back(e);
    end
    @(negedge clk);
    #1;
    rreq_a[inst] = 1'b0;
    cwe_a[inst]  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < N_INST; i++) begin
      rst_n_a[i]  = 1'b0;
      addr_a[i]   = '0;
      wdata_a[i]  = '0;
      funct3_a[i] = '0;
      rreq_a[i]   = 1'b0;
      cwe_a[i]    = 1'b0;
    end
    #3;
    for (int i = 0; i < N_INST; i++) begin
      checkOutput($sformatf("reset_rdy_inst%0d", i), {31'b0, rdy_a[i]}, 32'd1);
      checkOutput($sformatf("reset_rdata_inst%0d", i), rdata_a[i], 32'd0);
      checkOutput($sformatf("reset_err_inst%0d", i), {31'b0, err_a[i]}, 32'd0);
    end
    @(negedge clk);
    #2;
    for (int i = 0; i < N_INST; i++) rst_n_a[i] = 1'b1;

    $display("[TB] word store/load");
    applyStimulus(0, 0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 1, 32'h0000_0000, 0, 1);
    applyStimulus(0, 1, 0, 32'h10, 32'h0,        3'b010, 1, 32'hDEADBEEF, 0, 1);

    $display("[TB] byte/half stores and sign handling");
    applyStimulus(0, 0, 1, 32'h20, 32'h0000_0000, 3'b010, 1, 32'hDEADBEEF, 0, 1);
    applyStimulus(0, 0, 1, 32'h23, 32'h0000_0080, 3'b000, 1, 32'hDEADBEEF, 0, 1);
    applyStimulus(0, 1, 0, 32'h23, 32'h0,         3'b000, 1, 32'hFFFF_FF80, 0, 1);
    applyStimulus(0, 1, 0, 32'h23, 32'h0,         3'b100, 1, 32'h0000_0080, 0, 1);
    applyStimulus(0, 1, 0, 32'h22, 32'h0,         3'b001, 1, 32'hFFFF_8000, 0, 1);
    applyStimulus(0, 1, 0, 32'h22, 32'h0,         3'b101, 1, 32'h0000_8000, 0, 1);
    applyStimulus(0, 0, 1, 32'h20, 32'h1234_BEEF, 3'b001, 1, 32'h0000_8000, 0, 1);
    applyStimulus(0, 1, 0, 32'h20, 32'h0,         3'b010, 1, 32'h8000_BEEF, 0, 1);

    $display("[TB] misaligned and illegal accesses");
    applyStimulus(0, 1, 0, 32'h12, 32'h0,         3'b010, 1, 32'h0000_0000, 1, 1);
    applyStimulus(0, 0, 1, 32'h12, 32'h5555_5555, 3'b010, 1, 32'h0000_0000, 1, 1);
    applyStimulus(0, 1, 0, 32'h10, 32'h0,         3'b010, 1, 32'hDEADBEEF, 0, 1);
    applyStimulus(0, 1, 0, 32'h10, 32'h0,         3'b011, 1, 32'h0000_0000, 1, 1);
    applyStimulus(0, 0, 1, 32'h10, 32'h0000_0011, 3'b100, 1, 32'h0000_0000, 1, 1);
    applyStimulus(0, 1, 0, 32'h10, 32'h0,         3'b010, 1, 32'hDEADBEEF, 0, 1);

    $display("[TB] requests while busy, simultaneous rreq/cwe");
    applyStimulus(0, 1, 0, 32'h10, 32'h0,         3'b010, 1, 32'hDEADBEEF, 0, 1);
    applyStimulus(0, 0, 1, 32'h10, 32'h1111_1111, 3'b010, 0, 32'h0,        0, 0);
    applyStimulus(0, 1, 0, 32'h10, 32'h0,         3'b010, 1, 32'hDEADBEEF, 0, 1);
    applyStimulus(0, 1, 1, 32'h10, 32'hCAFE_F00D, 3'b010, 1, 32'hDEADBEEF, 0, 1);
    applyStimulus(0, 1, 0, 32'h10, 32'h0,         3'b010, 1, 32'hCAFE_F00D, 0, 1);

    $display("[TB] reset during a busy store");
    applyStimulus(0, 0, 1, 32'h40, 32'h1234_5678, 3'b010, 1, 32'hCAFE_F00D, 0, 1);
    applyStimulus(0, 0, 1, 32'h40, 32'hBADB_AD00, 3'b010, 0, 32'h0,        0, 1);
    #1;
    rst_n_a[0] = 1'b0;
    #1;
    checkOutput("midbusy_reset_rdy", {31'b0, rdy_a[0]}, 32'd1);
    checkOutput("midbusy_reset_rdata", rdata_a[0], 32'd0);
    checkOutput("midbusy_reset_err", {31'b0, err_a[0]}, 32'd0);
    @(negedge clk);
    #2;
    rst_n_a[0] = 1'b1;
    applyStimulus(0, 1, 0, 32'h40, 32'h0, 3'b010, 1, 32'h1234_5678, 0, 1);

    $display("[TB] address wrap across latencies");
    applyStimulus(0, 0, 1, 32'h1004,      32'h0F0F_3333, 3'b010, 1, 32'h1234_5678, 0, 1);
    applyStimulus(0, 1, 0, 32'h4,         32'h0,         3'b010, 1, 32'h0F0F_3333, 0, 1);
    applyStimulus(0, 1, 0, 32'hFFFF_F004, 32'h0,         3'b010, 1, 32'h0F0F_3333, 0, 1);
    applyStimulus(1, 0, 1, 32'h1004,      32'hA5A5_1111, 3'b010, 1, 32'h0000_0000, 0, 1);
    applyStimulus(1, 1, 0, 32'h4,         32'h0,         3'b010, 1, 32'hA5A5_1111, 0, 1);
    applyStimulus(2, 0, 1, 32'h1004,      32'h5A5A_2222, 3'b010, 1, 32'h0000_0000, 0, 1);
    applyStimulus(2, 1, 0, 32'h4,         32'h0,         3'b010, 1, 32'h5A5A_2222, 0, 1);
    applyStimulus(2, 1, 0, 32'h4,         32'h0,         3'b010, 1, 32'h5A5A_2222, 0, 1);
    applyStimulus(2, 0, 1, 32'h4,         32'h0000_0000, 3'b010, 0, 32'h0,        0, 0);
    applyStimulus(2, 1, 0, 32'h4,         32'h0,         3'b010, 1, 32'h5A5A_2222, 0, 1);

    waitDone(0);
    waitDone(1);
    waitDone(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
